csi2_lane_merger: RTL and testbench
===================================

Name: csi2_lane_merger

Overview:
- Receives per-lane HS byte streams from the multi-lane CSI-2 D-PHY receiver: NUM_LANES bytes, each lane with its own hs_sync and hs_d_en.
- Removes the inter-lane arrival skew with small per-lane FIFOs.
- Emits one lane-aligned word per byte clock for the downstream CSI-2 packet parser and RAW10 unpacker.
- Generalises the single-lane byte path (bd0/hs_sync/hs_d_en) to 1..4 lanes, and adds burst framing and skew-error detection.

Parameters:
- NUM_LANES, 2, number of data lanes, 1..4.
- FIFO_DEPTH, 8, entries per lane FIFO; power of 2, minimum 4.
- MAX_SKEW, 4, maximum tolerated cycles between the first and last lane hs_sync; must be <= FIFO_DEPTH-2.

Ports:
- clk_byte_i  in  1  byte clock; all lanes are already in this domain.
- reset_byte_n_i  in  1  asynchronous, active-low reset.
- bd_i  in  NUM_LANES*8  per-lane HS byte; lane k occupies bits [8k+7:8k].
- hs_sync_i  in  NUM_LANES  per-lane pulse, high with that lane's first payload byte after SoT.
- hs_d_en_i  in  NUM_LANES  per-lane HS burst active; the falling edge marks end of burst.
- word_o  out  NUM_LANES*8  aligned word; lane order preserved.
- word_valid_o  out  1  word_o qualifier.
- sot_o  out  1  one-cycle pulse coincident with the first word of a burst.
- eot_o  out  1  one-cycle pulse, the cycle after the last word of a burst.
- skew_err_o  out  1  one-cycle pulse on skew or early-end error.
- len_mismatch_o  out  1  one-cycle pulse, coincident with eot_o, when lanes ended with unequal byte counts.

Behaviour:
- Reset values: all outputs 0, state IDLE, all FIFO pointers 0, all per-lane sync flags cleared. Reset takes effect immediately and asynchronously at any point, including mid-burst; a burst in progress is discarded with no eot_o.
- Lane write enable wr_k:
  - Set in the cycle hs_sync_i[k]=1, in IDLE or ALIGN, while lane k is not yet synced.
  - The byte on that cycle is written.
  - Stays set while hs_d_en_i[k]=1; cleared when hs_d_en_i[k]=0.
  - hs_sync_i on an already-synced lane is ignored.
- States:
  - IDLE: on the first hs_sync, go to ALIGN, or straight to STREAM if all lanes sync in that cycle. The skew counter starts at 0.
  - ALIGN:
    - The skew counter increments each cycle.
    - When all lanes are synced, go to STREAM.
    - If the counter exceeds MAX_SKEW, or any synced lane drops hs_d_en first, pulse skew_err_o and go to ERR.
  - STREAM:
    - Pop all FIFOs together whenever every FIFO is non-empty.
    - word_o and word_valid_o are registered from the pop.
    - When every wr_k is 0, go to DRAIN.
  - DRAIN:
    - Pop while all FIFOs are non-empty.
    - When any FIFO is empty, pulse eot_o, flush all FIFOs (pulse len_mismatch_o if any FIFO still held data), clear sync flags, go to IDLE.
  - ERR: flush FIFOs and hold until all hs_d_en_i are 0, then go to IDLE. No words are emitted.
- Latency:
  - The first word_valid_o is 2 cycles after the cycle the last lane's hs_sync_i is high, with sot_o high in the same cycle.
  - Words are contiguous thereafter (one per cycle) while all lanes keep writing.
- Simultaneous events:
  - A hs_sync in the same cycle as ERR→IDLE is ignored.
  - In IDLE, a hs_sync and an hs_d_en fall in the same cycle: the lane is synced, but wr_k clears the next cycle.
- FIFO full: a write to a full FIFO is dropped and pulses skew_err_o. This is unreachable when MAX_SKEW <= FIFO_DEPTH-2.
- NUM_LANES=1: ALIGN is bypassed; the block behaves as a 2-cycle byte pipeline with framing.

Optional Feature:
- Macro CSI2_MERGE_STATS_EN.
- When defined, two extra outputs are added:
  - skew_o [$clog2(MAX_SKEW+1)-1:0]: skew counter value at the ALIGN→STREAM transition.
  - burst_len_o [15:0]: words emitted in the last completed burst, saturating at 16'hFFFF.
- Both update at the eot_o cycle and reset to 0.
- When undefined, neither port nor the counters exist.

Decomposition:
- Package csi2_rx_pkg:
  - LANE_W=8.
  - Enumerated state type merge_state_t {IDLE, ALIGN, STREAM, DRAIN, ERR}.
  - Helper function lane_slice.
- Sub-module csi2_lane_fifo: synchronous single-clock FIFO with empty/full and a flush input. One instance per lane via generate.

Test Plan:
- Skew 0: NUM_LANES=2, both hs_sync at cycle 10, lane0 bytes 0x10.., lane1 0x20.., 6 bytes each. Expect word_valid_o at cycles 12–17, words 0x2010..0x2515, sot_o@12, eot_o@18, no errors.
- Skew 3: lane1 sync 3 cycles after lane0, equal 8-byte bursts. Expect 8 words with pairs (0x10,0x20)..(0x17,0x27), first word 2 cycles after lane1 sync, skew_o=3 with stats enabled.
- Over-skew: lane1 sync 5 cycles after lane0 with MAX_SKEW=4. Expect skew_err_o pulse, no word_valid_o, back in IDLE after all hs_d_en low; a following clean burst merges correctly.
- Unequal end: lane0 sends 6 bytes, lane1 sends 7. Expect 6 words, eot_o with len_mismatch_o=1, FIFOs empty afterwards.
- Reset mid-burst: assert reset_byte_n_i low after 3 words of a 10-byte burst. Expect all outputs 0 immediately, no eot_o; the next burst is merged from its first byte.
- NUM_LANES=1: 4-byte burst 0xA0..0xA3 with sync at cycle 5. Expect words at cycles 7–10, sot_o@7, eot_o@11.

Source files
------------

// File: rtl/csi2_rx_pkg.sv
// Shared definitions for the CSI-2 receive byte path: lane width, merger
// FSM state type and a helper to pick one lane's byte out of a packed bus.
package csi2_rx_pkg;

    localparam int LANE_W    = 8;
    localparam int MAX_LANES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        ERR    = 3'd4
    } merge_state_t;

    // Byte of lane k from a bus sized for the widest lane configuration.
    function automatic logic [LANE_W-1:0] lane_slice(
        input logic [MAX_LANES*LANE_W-1:0] bus,
        input int                          k
    );
        return bus[k*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/csi2_lane_fifo.sv
// Single-clock per-lane skew FIFO. Read data is taken straight from the
// array so a pop in cycle N can be registered by the merger in the same
// cycle; the array is small enough to live in distributed RAM.
module csi2_lane_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         wr_i,
    input  logic [W-1:0] din_i,
    input  logic         rd_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_wr;
    logic         do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_i & ~full_o;
    assign do_rd   = rd_i & ~empty_o;
    assign dout_o  = mem[rd_ptr_q[AW-1:0]];

    // Storage array; writes to a full FIFO are dropped.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    // Pointers; flush wins over any write or read in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/csi2_lane_merger.sv
// Multi-lane CSI-2 byte merger: per-lane FIFOs absorb hs_sync arrival skew,
// then all lanes are popped together to form one aligned word per cycle.
// Optional burst statistics (skew_o, burst_len_o) exist only when the
// macro CSI2_MERGE_STATS_EN is defined.
module csi2_lane_merger
    import csi2_rx_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_SKEW   = 4
) (
    input  logic                        clk_byte_i,
    input  logic                        reset_byte_n_i,
    input  logic [NUM_LANES*LANE_W-1:0] bd_i,
    input  logic [NUM_LANES-1:0]        hs_sync_i,
    input  logic [NUM_LANES-1:0]        hs_d_en_i,
    output logic [NUM_LANES*LANE_W-1:0] word_o,
    output logic                        word_valid_o,
    output logic                        sot_o,
    output logic                        eot_o,
    output logic                        skew_err_o,
`ifdef CSI2_MERGE_STATS_EN
    output logic [$clog2(MAX_SKEW+1)-1:0] skew_o,
    output logic [15:0]                 burst_len_o,
`endif
    output logic                        len_mismatch_o
);
    localparam int                    SKEW_W     = $clog2(MAX_SKEW + 1);
    localparam logic [SKEW_W-1:0]     MAX_SKEW_C = SKEW_W'(MAX_SKEW);
    localparam logic [NUM_LANES-1:0]  ALL_LANES  = '1;

    merge_state_t                state_q, state_d;
    logic [NUM_LANES-1:0]        synced_q, synced_d;
    logic [NUM_LANES-1:0]        active_q, active_d;
    logic [SKEW_W-1:0]           cnt_q, cnt_d;
    logic                        first_q, first_d;
    logic [NUM_LANES-1:0]        sync_start, wr, empty, full, ovf;
    logic [NUM_LANES*LANE_W-1:0] dout, word_q;
    logic [MAX_LANES*LANE_W-1:0] bd_ext;
    logic                        sync_window, all_nonempty, pop, flush;
    logic                        word_valid_q, sot_q, eot_q, skew_err_q, len_mis_q;
    logic                        eot_d, skew_err_d, len_mis_d;

    // A lane starts writing on its first hs_sync while the burst is still
    // being aligned, then keeps writing for as long as its hs_d_en is high.
    assign sync_window  = (state_q == IDLE) || (state_q == ALIGN);
    assign sync_start   = hs_sync_i & ~synced_q & {NUM_LANES{sync_window}};
    assign wr           = sync_start | (active_q & hs_d_en_i);
    assign active_d     = wr & hs_d_en_i;
    assign ovf          = wr & full;
    assign all_nonempty = ~|empty;
    assign pop          = ((state_q == STREAM) || (state_q == DRAIN)) && all_nonempty;

    // Widen the input bus so every lane can be sliced with one helper.
    always_comb begin
        bd_ext = '0;
        bd_ext[NUM_LANES*LANE_W-1:0] = bd_i;
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        csi2_lane_fifo #(
            .W     (LANE_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_byte_i),
            .rst_ni  (reset_byte_n_i),
            .flush_i (flush),
            .wr_i    (wr[gi]),
            .din_i   (lane_slice(bd_ext, gi)),
            .rd_i    (pop),
            .dout_o  (dout[gi*LANE_W +: LANE_W]),
            .empty_o (empty[gi]),
            .full_o  (full[gi])
        );
    end

    // Burst framing FSM: align lane starts, stream, drain, or abort on error.
    always_comb begin
        state_d    = state_q;
        synced_d   = synced_q | sync_start;
        cnt_d      = cnt_q;
        first_d    = first_q & ~pop;
        flush      = 1'b0;
        eot_d      = 1'b0;
        skew_err_d = |ovf;
        len_mis_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|sync_start) begin
                    if (synced_d == ALL_LANES) begin
                        state_d = STREAM;
                        first_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                // cnt_q+1 cycles have elapsed since the first lane synced.
                if ((cnt_q >= MAX_SKEW_C) || |(synced_q & ~hs_d_en_i)) begin
                    state_d    = ERR;
                    skew_err_d = 1'b1;
                end else if (synced_d == ALL_LANES) begin
                    state_d = STREAM;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + SKEW_W'(1);
                end
            end
            STREAM: begin
                if (wr == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (!all_nonempty) begin
                    eot_d     = 1'b1;
                    len_mis_d = |(~empty);
                    flush     = 1'b1;
                    synced_d  = '0;
                    state_d   = IDLE;
                end
            end
            ERR: begin
                flush = 1'b1;
                if (hs_d_en_i == '0) begin
                    synced_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                synced_d = '0;
            end
        endcase
    end

    // State and output registers; reset discards any burst in flight.
    always_ff @(posedge clk_byte_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            state_q      <= IDLE;
            synced_q     <= '0;
            active_q     <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            sot_q        <= 1'b0;
            eot_q        <= 1'b0;
            skew_err_q   <= 1'b0;
            len_mis_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            synced_q     <= synced_d;
            active_q     <= active_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            if (pop) word_q <= dout;
            word_valid_q <= pop;
            sot_q        <= pop & first_q;
            eot_q        <= eot_d;
            skew_err_q   <= skew_err_d;
            len_mis_q    <= len_mis_d;
        end
    end

    assign word_o         = word_q;
    assign word_valid_o   = word_valid_q;
    assign sot_o          = sot_q;
    assign eot_o          = eot_q;
    assign skew_err_o     = skew_err_q;
    assign len_mismatch_o = len_mis_q;

`ifdef CSI2_MERGE_STATS_EN
    logic [SKEW_W-1:0] skew_rec_q, skew_out_q;
    logic [15:0]       pop_cnt_q, burst_len_q;

    // Capture skew at stream entry and count words; publish both at eot.
    always_ff @(posedge clk_byte_i or negedge reset_byte_n_i) begin
        if (!reset_byte_n_i) begin
            skew_rec_q  <= '0;
            skew_out_q  <= '0;
            pop_cnt_q   <= '0;
            burst_len_q <= '0;
        end else begin
            if ((state_q != STREAM) && (state_d == STREAM)) begin
                skew_rec_q <= (state_q == ALIGN) ? cnt_q + SKEW_W'(1) : '0;
            end
            if (state_q == IDLE) begin
                pop_cnt_q <= '0;
            end else if (pop && (pop_cnt_q != 16'hFFFF)) begin
                pop_cnt_q <= pop_cnt_q + 16'd1;
            end
            if (eot_d) begin
                skew_out_q  <= skew_rec_q;
                burst_len_q <= pop_cnt_q;
            end
        end
    end

    assign skew_o      = skew_out_q;
    assign burst_len_o = burst_len_q;
`endif

endmodule

// File: tb/tb_csi2_lane_merger.sv
// Directed bench for csi2_lane_merger: a 2-lane instance plus a 1-lane
// instance that listens to lane 0 of the same stimulus.
module tb_csi2_lane_merger;
    localparam int NCYC = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] bd;
    logic [1:0]  sync, den;
    logic [15:0] word;
    logic        wv, sot, eot, serr, lmis;
    logic [7:0]  word1;
    logic        wv1, sot1, eot1, serr1, lmis1;
`ifdef CSI2_MERGE_STATS_EN
    logic [2:0]  skew, skew1;
    logic [15:0] blen, blen1;
`endif

    csi2_lane_merger #(.NUM_LANES(2), .FIFO_DEPTH(8), .MAX_SKEW(4)) dut (
        .clk_byte_i     (clk),
        .reset_byte_n_i (rst_n),
        .bd_i           (bd),
        .hs_sync_i      (sync),
        .hs_d_en_i      (den),
        .word_o         (word),
        .word_valid_o   (wv),
        .sot_o          (sot),
        .eot_o          (eot),
        .skew_err_o     (serr),
`ifdef CSI2_MERGE_STATS_EN
        .skew_o         (skew),
        .burst_len_o    (blen),
`endif
        .len_mismatch_o (lmis)
    );

    csi2_lane_merger #(.NUM_LANES(1), .FIFO_DEPTH(8), .MAX_SKEW(4)) dut1 (
        .clk_byte_i     (clk),
        .reset_byte_n_i (rst_n),
        .bd_i           (bd[7:0]),
        .hs_sync_i      (sync[0]),
        .hs_d_en_i      (den[0]),
        .word_o         (word1),
        .word_valid_o   (wv1),
        .sot_o          (sot1),
        .eot_o          (eot1),
        .skew_err_o     (serr1),
`ifdef CSI2_MERGE_STATS_EN
        .skew_o         (skew1),
        .burst_len_o    (blen1),
`endif
        .len_mismatch_o (lmis1)
    );

    int checks = 0;
    int passes = 0;

    // Per-cycle observation logs: {valid, sot, eot, skew_err, len_mismatch}.
    logic [4:0]  st_log  [NCYC];
    logic [15:0] w_log   [NCYC];
    logic [4:0]  st1_log [NCYC];
    logic [7:0]  w1_log  [NCYC];

    // Drive one burst window; lane k sends n_k bytes from b_k starting at s_k.
    // Reset is pulled low for two cycles starting at rst_at (if >= 0).
    task automatic run_burst(input int s0, input int n0, input int s1, input int n1,
                             input logic [7:0] b0, input logic [7:0] b1, input int rst_at);
        for (int t = 0; t < NCYC; t++) begin
            @(posedge clk);
            #1;
            if (rst_at >= 0 && t == rst_at) rst_n = 1'b0;
            else if (rst_at >= 0 && t == rst_at + 2) rst_n = 1'b1;
            den[0]    = (t >= s0) && (t < s0 + n0);
            sync[0]   = (t == s0) && (n0 > 0);
            bd[7:0]   = den[0] ? 8'(b0 + t - s0) : 8'h00;
            den[1]    = (t >= s1) && (t < s1 + n1);
            sync[1]   = (t == s1) && (n1 > 0);
            bd[15:8]  = den[1] ? 8'(b1 + t - s1) : 8'h00;
            #1;
            st_log[t]  = {wv, sot, eot, serr, lmis};
            w_log[t]   = word;
            st1_log[t] = {wv1, sot1, eot1, serr1, lmis1};
            w1_log[t]  = word1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bd = '0; sync = '0; den = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wv, sot, eot, serr, lmis, word} !== 21'd0) begin
            $display("FAIL reset_outputs got=%b/%h want=0", {wv, sot, eot, serr, lmis}, word);
        end else passes++;
        checks++;
        if ({wv1, sot1, eot1, serr1, lmis1, word1} !== 13'd0) begin
            $display("FAIL reset_outputs_1lane got=%b/%h want=0", {wv1, sot1, eot1, serr1, lmis1}, word1);
        end else passes++;
`ifdef CSI2_MERGE_STATS_EN
        checks++;
        if ({skew, blen} !== 19'd0) begin
            $display("FAIL reset_stats got=%0d/%0d want=0/0", skew, blen);
        end else passes++;
`endif
        rst_n = 1'b1;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_skew0();
        logic [4:0]  es;
        logic [15:0] ew;
        run_burst(10, 6, 10, 6, 8'h10, 8'h20, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 12 && t <= 17), (t == 12), (t == 18), 1'b0, 1'b0};
            checks++;
            if (st_log[t] !== es) $display("FAIL skew0_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
            if (es[4]) begin
                ew = {8'(8'h20 + t - 12), 8'(8'h10 + t - 12)};
                checks++;
                if (w_log[t] !== ew) $display("FAIL skew0_word t=%0d got=%h want=%h", t, w_log[t], ew);
                else passes++;
            end
        end
        $display("test_skew0: 6-byte aligned burst");
    endtask

    task automatic test_skew3();
        logic [4:0]  es;
        logic [15:0] ew;
        run_burst(10, 8, 13, 8, 8'h10, 8'h20, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 15 && t <= 22), (t == 15), (t == 23), 1'b0, 1'b0};
            checks++;
            if (st_log[t] !== es) $display("FAIL skew3_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
            if (es[4]) begin
                ew = {8'(8'h20 + t - 15), 8'(8'h10 + t - 15)};
                checks++;
                if (w_log[t] !== ew) $display("FAIL skew3_word t=%0d got=%h want=%h", t, w_log[t], ew);
                else passes++;
            end
        end
`ifdef CSI2_MERGE_STATS_EN
        checks++;
        if (skew !== 3'd3) $display("FAIL skew3_skew_o got=%0d want=3", skew);
        else passes++;
        checks++;
        if (blen !== 16'd8) $display("FAIL skew3_burst_len got=%0d want=8", blen);
        else passes++;
`endif
        $display("test_skew3: 8-byte burst with lane1 3 cycles late");
    endtask

    task automatic test_overskew();
        logic [4:0]  es;
        logic [15:0] ew;
        run_burst(10, 8, 15, 8, 8'h10, 8'h20, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {1'b0, 1'b0, 1'b0, (t == 16), 1'b0};
            checks++;
            if (st_log[t] !== es) $display("FAIL overskew_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
        end
        run_burst(10, 4, 10, 4, 8'h30, 8'h40, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 12 && t <= 15), (t == 12), (t == 16), 1'b0, 1'b0};
            checks++;
            if (st_log[t] !== es) $display("FAIL overskew_recover_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
            if (es[4]) begin
                ew = {8'(8'h40 + t - 12), 8'(8'h30 + t - 12)};
                checks++;
                if (w_log[t] !== ew) $display("FAIL overskew_recover_word t=%0d got=%h want=%h", t, w_log[t], ew);
                else passes++;
            end
        end
        $display("test_overskew: 5-cycle skew rejected, clean burst follows");
    endtask

    task automatic test_unequal();
        logic [4:0]  es;
        logic [15:0] ew;
        run_burst(10, 6, 10, 7, 8'h50, 8'h60, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 12 && t <= 17), (t == 12), (t == 19), 1'b0, (t == 19)};
            checks++;
            if (st_log[t] !== es) $display("FAIL unequal_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
            if (es[4]) begin
                ew = {8'(8'h60 + t - 12), 8'(8'h50 + t - 12)};
                checks++;
                if (w_log[t] !== ew) $display("FAIL unequal_word t=%0d got=%h want=%h", t, w_log[t], ew);
                else passes++;
            end
        end
        run_burst(10, 3, 10, 3, 8'h70, 8'h80, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 12 && t <= 14), (t == 12), (t == 15), 1'b0, 1'b0};
            checks++;
            if (st_log[t] !== es) $display("FAIL unequal_after_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
            if (es[4]) begin
                ew = {8'(8'h80 + t - 12), 8'(8'h70 + t - 12)};
                checks++;
                if (w_log[t] !== ew) $display("FAIL unequal_after_word t=%0d got=%h want=%h", t, w_log[t], ew);
                else passes++;
            end
        end
        $display("test_unequal: 6 vs 7 byte lanes, leftovers flushed");
    endtask

    task automatic test_reset_mid();
        logic [4:0]  es;
        logic [15:0] ew;
        run_burst(10, 10, 10, 10, 8'h10, 8'h20, 15);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 12 && t <= 14), (t == 12), 1'b0, 1'b0, 1'b0};
            checks++;
            if (st_log[t] !== es) $display("FAIL reset_mid_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
            if (t >= 12) begin
                ew = es[4] ? {8'(8'h20 + t - 12), 8'(8'h10 + t - 12)} : 16'h0000;
                checks++;
                if (w_log[t] !== ew) $display("FAIL reset_mid_word t=%0d got=%h want=%h", t, w_log[t], ew);
                else passes++;
            end
        end
        run_burst(10, 4, 10, 4, 8'h90, 8'hA0, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 12 && t <= 15), (t == 12), (t == 16), 1'b0, 1'b0};
            checks++;
            if (st_log[t] !== es) $display("FAIL reset_after_status t=%0d got=%b want=%b", t, st_log[t], es);
            else passes++;
            if (es[4]) begin
                ew = {8'(8'hA0 + t - 12), 8'(8'h90 + t - 12)};
                checks++;
                if (w_log[t] !== ew) $display("FAIL reset_after_word t=%0d got=%h want=%h", t, w_log[t], ew);
                else passes++;
            end
        end
        $display("test_reset_mid: burst cut by reset, next burst merged");
    endtask

    task automatic test_single_lane();
        logic [4:0] es;
        logic [7:0] ew;
        run_burst(5, 4, 0, 0, 8'hA0, 8'h00, -1);
        for (int t = 0; t < NCYC; t++) begin
            es = {(t >= 7 && t <= 10), (t == 7), (t == 11), 1'b0, 1'b0};
            checks++;
            if (st1_log[t] !== es) $display("FAIL single_status t=%0d got=%b want=%b", t, st1_log[t], es);
            else passes++;
            if (es[4]) begin
                ew = 8'(8'hA0 + t - 7);
                checks++;
                if (w1_log[t] !== ew) $display("FAIL single_word t=%0d got=%h want=%h", t, w1_log[t], ew);
                else passes++;
            end
        end
        $display("test_single_lane: 4-byte burst on 1-lane instance");
    endtask

    initial begin
        test_reset();
        test_skew0();
        test_skew3();
        test_overskew();
        test_unequal();
        test_reset_mid();
        test_single_lane();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
